// File: rtl/rv_pkg.sv
// Shared widths and the writeback request record used by the writeback arbiter.
package rv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, one-bit lastGrant register.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_block,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant
);

  // Index of the requester granted most recently; reset to 1 so requester 0 wins the first tie.
  logic last_grant_q;
  logic last_grant_d;

  // Grant decode: a lone requester wins outright, a tie goes to the one not granted last.
  always_comb begin
    o_grant = 2'b00;
    if (!i_block) begin
      unique case (i_valid)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = last_grant_q ? 2'b01 : 2'b10;
        default: o_grant = 2'b00;
      endcase
    end
  end

  // Every grant is a transfer, so lastGrant follows the grant vector directly.
  always_comb begin
    last_grant_d = last_grant_q;
    if (o_grant[0]) begin
      last_grant_d = 1'b0;
    end else if (o_grant[1]) begin
      last_grant_d = 1'b1;
    end
  end

  // lastGrant register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one of two writeback sources per cycle and registers the
// register-file write port one cycle after the transfer.
module wb_arbiter
  import rv_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_wbValid0,
  input  logic [REG_ADDR_W-1:0] i_wbRd0,
  input  logic [XLEN-1:0]       i_wbData0,
  output logic                  o_wbReady0,
  input  logic                  i_wbValid1,
  input  logic [REG_ADDR_W-1:0] i_wbRd1,
  input  logic [XLEN-1:0]       i_wbData1,
  output logic                  o_wbReady1,
  output logic                  o_regWrite,
  output logic [REG_ADDR_W-1:0] o_writeRegSelect,
  output logic [XLEN-1:0]       o_dataIn,
  output logic                  o_conflict
);

  wb_req_t req0;
  wb_req_t req1;
  wb_req_t win;
  logic [1:0] grant;

  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] sel_q, sel_d;
  logic [XLEN-1:0]       data_q, data_d;

  assign req0 = '{valid: i_wbValid0, rd: i_wbRd0, data: i_wbData0};
  assign req1 = '{valid: i_wbValid1, rd: i_wbRd1, data: i_wbData1};

  // Reset blocks grants too, so a request pending across reset is held, not lost.
  rr_arb2 u_rr_arb2 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_block (i_flush | i_rst),
    .i_valid ({req1.valid, req0.valid}),
    .o_grant (grant)
  );

  assign o_wbReady0 = grant[0];
  assign o_wbReady1 = grant[1];

  // Same-rd hazard flag only; arbitration order decides which write lands last.
  assign o_conflict = req0.valid && req1.valid && (req0.rd == req1.rd) && (req0.rd != '0);

  // Select the transferring request and form next write-port values.
  always_comb begin
    win         = grant[1] ? req1 : req0;
    reg_write_d = 1'b0;
    sel_d       = sel_q;
    data_d      = data_q;
    if (grant != 2'b00) begin
      // x0 is architecturally zero: address/data still load, but the write is dropped.
      reg_write_d = (win.rd != '0);
      sel_d       = win.rd;
      data_d      = win.data;
    end
  end

  // Registered write port, latency one cycle after the transfer edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      reg_write_q <= 1'b0;
      sel_q       <= '0;
      data_q      <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      sel_q       <= sel_d;
      data_q      <= data_d;
    end
  end

  assign o_regWrite       = reg_write_q;
  assign o_writeRegSelect = sel_q;
  assign o_dataIn         = data_q;

endmodule
